icu_mc14500_core: RTL and testbench
===================================

// Module: icu_mc14500_core
// PURPOSE
//  - 1-bit industrial control unit (MC14500-style). Executes one 4-bit instruction per accepted cycle.
//  - Sits directly upstream of the mc14599 8-bit addressable output latch.
//  - Drives the latch's address, data and write-disable pins, plus the JMP/RTN/FLAG strobes to the program sequencer.
// PARAMETERS
//  ADDR_W   3   width of I/O address field; also width of lat_addr (3 = 8 latch bits)
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       reset, synchronous, active-low
//  instr_valid    in   1       instr/io_addr/data_in valid this cycle; sampled on clk edge
//  instr          in   4       opcode
//  io_addr        in   ADDR_W  I/O address accompanying instr
//  data_in        in   1       selected input bit for io_addr (external input mux)
//  lat_addr       out  ADDR_W  latch bit address; updated only on a write
//  lat_data       out  1       latch data bit; updated only on a write
//  lat_w_disable  out  1       0 for exactly one cycle per write; 1 otherwise
//  jmp            out  1       1-cycle pulse on executed JMP
//  rtn            out  1       1-cycle pulse on executed RTN
//  flag_o         out  1       1-cycle pulse on executed NOPO
//  flag_f         out  1       1-cycle pulse on executed NOPF
//  rr             out  1       result register
//  ien            out  1       input-enable register
//  oen            out  1       output-enable register
//  skip           out  1       next accepted instruction will be discarded
// BEHAVIOUR
//  - Reset (reset==0 at edge): rr=ien=oen=skip=0; jmp=rtn=flag_o=flag_f=0; lat_w_disable=1; lat_addr=0; lat_data=0.
//  - Reset takes priority over instr_valid. A write or pulse due that edge is lost.
//  - All outputs are registered. Effects of an instruction accepted at edge N are visible after edge N.
//  - Pulses (jmp, rtn, flag_o, flag_f, ~lat_w_disable) are one cycle wide; they clear on the next edge regardless of instr_valid.
//  - instr_valid==0: rr, ien, oen, skip, lat_addr, lat_data hold; pulses deassert.
//  - Gated data: di = data_in & ien.
//  - Skip: if skip==1 and instr_valid==1, the instruction is consumed with no effect (no pulses, no write, no register change) and skip clears.
//  - Opcodes (executed when not skipped):
//    0 NOPO  flag_o pulse
//    1 LD    rr=di
//    2 LDC   rr=~di
//    3 AND   rr&=di
//    4 ANDC  rr&=~di
//    5 OR    rr|=di
//    6 ORC   rr|=~di
//    7 XNOR  rr=~(rr^di)
//    8 STO   if oen: lat_addr=io_addr, lat_data=rr, write pulse
//    9 STOC  same as STO, with lat_data=~rr
//    A IEN   ien=data_in (ungated)
//    B OEN   oen=data_in (ungated)
//    C JMP   jmp pulse
//    D RTN   rtn pulse; skip=1
//    E SKZ   skip=(rr==0)
//    F NOPF  flag_f pulse
//  - STO/STOC with oen==0: no write; lat_addr and lat_data hold; rr unchanged.
//  - Back-to-back STOs on consecutive cycles: lat_w_disable stays 0 across both.
//    lat_addr/lat_data change at each edge, so the latch captures each bit in its own cycle.
//  - SKZ followed by SKZ with rr==0: the second SKZ is skipped; skip ends at 0.
// STRUCTURE
//  - Shared package icu_pkg: localparam opcodes OP_NOPO..OP_NOPF (4'h0..4'hF); ICU_ADDR_W=3.
//  - Sub-module icu_logic_unit (combinational): inputs opcode, rr, di; outputs rr_next and lu_op (1 for opcodes 1-7).
//  - Core holds the registers, skip/enable control and the output/pulse registers.
// TESTING
//  1. reset=0 for 2 cycles with instr_valid=1 and instr=STO -> all outputs at reset values, lat_w_disable=1.
//  2. IEN d=1; OEN d=1; LD d=1; STO addr=5 -> next cycle lat_addr=5, lat_data=1, lat_w_disable=0 for 1 cycle.
//  3. ien=0, then LD d=1 -> rr=0. Then OEN d=0; STO -> lat_w_disable stays 1, lat_addr/lat_data unchanged.
//  4. rr=0; SKZ; LD (d=1, ien=1) -> LD discarded, rr=0, skip clears.
//     With rr=1, the same sequence -> rr=1.
//  5. RTN; JMP -> rtn pulses once; JMP skipped (no jmp pulse); following NOPO -> flag_o pulses.
//  6. Walk STO/STOC over addr 0..7 with alternating rr -> 8 single-cycle writes, data matches.
//     Assert reset mid-sequence -> no write that edge; rr=ien=oen=0.

Source files
------------

// File: rtl/icu_pkg.sv
// Shared definitions for the MC14500-style 1-bit industrial control unit.
//   ICU_ADDR_W : default I/O / latch address width (8 latch bits)
//   OP_*       : 4-bit opcode encodings
package icu_pkg;

  localparam int unsigned ICU_ADDR_W = 3;

  localparam logic [3:0] OP_NOPO = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_LDC  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_ANDC = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_ORC  = 4'h6;
  localparam logic [3:0] OP_XNOR = 4'h7;
  localparam logic [3:0] OP_STO  = 4'h8;
  localparam logic [3:0] OP_STOC = 4'h9;
  localparam logic [3:0] OP_IEN  = 4'hA;
  localparam logic [3:0] OP_OEN  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_RTN  = 4'hD;
  localparam logic [3:0] OP_SKZ  = 4'hE;
  localparam logic [3:0] OP_NOPF = 4'hF;

endpackage

// File: rtl/icu_mc14500_core_if.sv
// Instruction / output bus of the control unit.
//   master : instruction source (drives instr_valid, instr, io_addr, data_in)
//   slave  : icu_mc14500_core (drives latch pins, strobes and register views)
interface icu_mc14500_core_if #(
  parameter int unsigned ADDR_W = 3
);
  logic              instr_valid;
  logic [3:0]        instr;
  logic [ADDR_W-1:0] io_addr;
  logic              data_in;
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_data;
  logic              lat_w_disable;
  logic              jmp;
  logic              rtn;
  logic              flag_o;
  logic              flag_f;
  logic              rr;
  logic              ien;
  logic              oen;
  logic              skip;

  modport master (
    output instr_valid, instr, io_addr, data_in,
    input  lat_addr, lat_data, lat_w_disable, jmp, rtn, flag_o, flag_f, rr, ien, oen, skip
  );

  modport slave (
    input  instr_valid, instr, io_addr, data_in,
    output lat_addr, lat_data, lat_w_disable, jmp, rtn, flag_o, flag_f, rr, ien, oen, skip
  );
endinterface

// File: rtl/icu_logic_unit.sv
// Combinational 1-bit logic unit.
//   opcode  : current instruction
//   rr, di  : result register and gated input bit
//   rr_next : new result register value for logic opcodes
//   lu_op   : 1 when opcode is one of LD..XNOR (rr_next is meaningful)
module icu_logic_unit
  import icu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       rr,
  input  logic       di,
  output logic       rr_next,
  output logic       lu_op
);

  always_comb begin
    rr_next = rr;
    lu_op   = 1'b1;
    unique case (opcode)
      OP_LD:   rr_next = di;
      OP_LDC:  rr_next = ~di;
      OP_AND:  rr_next = rr & di;
      OP_ANDC: rr_next = rr & ~di;
      OP_OR:   rr_next = rr | di;
      OP_ORC:  rr_next = rr | ~di;
      OP_XNOR: rr_next = ~(rr ^ di);
      default: lu_op = 1'b0;
    endcase
  end

endmodule

// File: rtl/icu_mc14500_core.sv
// MC14500-style 1-bit control unit core. Executes one instruction per accepted cycle and
// drives an mc14599 addressable latch plus JMP/RTN/FLAG strobes.
//   clk   : rising-edge clock
//   reset : synchronous, active-low
//   bus   : slave side of icu_mc14500_core_if (instruction in, latch/strobes/registers out)
module icu_mc14500_core
  import icu_pkg::*;
#(
  parameter int unsigned ADDR_W = ICU_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  icu_mc14500_core_if.slave  bus
);

  logic              rr_q, rr_d, ien_q, ien_d, oen_q, oen_d, skip_q, skip_d;
  logic              jmp_q, jmp_d, rtn_q, rtn_d, flag_o_q, flag_o_d, flag_f_q, flag_f_d;
  logic              lat_w_dis_q, lat_w_dis_d, lat_data_q, lat_data_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic              di, lu_rr_next, lu_op;

  assign di = bus.data_in & ien_q;

  icu_logic_unit u_lu (
    .opcode  (bus.instr),
    .rr      (rr_q),
    .di      (di),
    .rr_next (lu_rr_next),
    .lu_op   (lu_op)
  );

  always_comb begin
    rr_d        = rr_q;
    ien_d       = ien_q;
    oen_d       = oen_q;
    skip_d      = skip_q;
    lat_addr_d  = lat_addr_q;
    lat_data_d  = lat_data_q;
    // Pulses self-clear every cycle unless re-armed below.
    jmp_d       = 1'b0;
    rtn_d       = 1'b0;
    flag_o_d    = 1'b0;
    flag_f_d    = 1'b0;
    lat_w_dis_d = 1'b1;
    if (bus.instr_valid) begin
      if (skip_q) begin
        skip_d = 1'b0;
      end else begin
        if (lu_op) rr_d = lu_rr_next;
        unique case (bus.instr)
          OP_NOPO: flag_o_d = 1'b1;
          OP_STO, OP_STOC: begin
            if (oen_q) begin
              lat_addr_d  = bus.io_addr;
              lat_data_d  = (bus.instr == OP_STOC) ? ~rr_q : rr_q;
              lat_w_dis_d = 1'b0;
            end
          end
          OP_IEN:  ien_d    = bus.data_in;  // enables load from the raw input
          OP_OEN:  oen_d    = bus.data_in;
          OP_JMP:  jmp_d    = 1'b1;
          OP_RTN: begin
            rtn_d  = 1'b1;
            skip_d = 1'b1;
          end
          OP_SKZ:  skip_d   = ~rr_q;
          OP_NOPF: flag_f_d = 1'b1;
          default: ;  // logic opcodes are handled by the logic unit
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_q        <= 1'b0;
      ien_q       <= 1'b0;
      oen_q       <= 1'b0;
      skip_q      <= 1'b0;
      jmp_q       <= 1'b0;
      rtn_q       <= 1'b0;
      flag_o_q    <= 1'b0;
      flag_f_q    <= 1'b0;
      lat_w_dis_q <= 1'b1;
      lat_addr_q  <= '0;
      lat_data_q  <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      ien_q       <= ien_d;
      oen_q       <= oen_d;
      skip_q      <= skip_d;
      jmp_q       <= jmp_d;
      rtn_q       <= rtn_d;
      flag_o_q    <= flag_o_d;
      flag_f_q    <= flag_f_d;
      lat_w_dis_q <= lat_w_dis_d;
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
    end
  end

  assign bus.rr            = rr_q;
  assign bus.ien           = ien_q;
  assign bus.oen           = oen_q;
  assign bus.skip          = skip_q;
  assign bus.jmp           = jmp_q;
  assign bus.rtn           = rtn_q;
  assign bus.flag_o        = flag_o_q;
  assign bus.flag_f        = flag_f_q;
  assign bus.lat_w_disable = lat_w_dis_q;
  assign bus.lat_addr      = lat_addr_q;
  assign bus.lat_data      = lat_data_q;

endmodule

// File: tb/tb_icu_mc14500_core.sv
// Self-checking bench for icu_mc14500_core: directed scenarios plus randomized traffic,
// all compared against a behavioural model of the instruction set.
module tb_icu_mc14500_core;
  import icu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  icu_mc14500_core_if #(.ADDR_W(3)) bus ();

  icu_mc14500_core #(.ADDR_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Reference model state.
  bit       m_rr, m_ien, m_oen, m_skip, m_jmp, m_rtn, m_fo, m_ff, m_wdis, m_data;
  bit [2:0] m_addr;
  // Truth tables for logic opcodes, indexed by {rr, di}.
  logic [3:0] lu_tt [16];

  // Packed view: {rr,ien,oen,skip,jmp,rtn,flag_o,flag_f,lat_w_disable,lat_addr,lat_data}
  function automatic logic [12:0] obs();
    return {bus.rr, bus.ien, bus.oen, bus.skip, bus.jmp, bus.rtn, bus.flag_o, bus.flag_f,
            bus.lat_w_disable, bus.lat_addr, bus.lat_data};
  endfunction

  function automatic logic [12:0] expv();
    return {m_rr, m_ien, m_oen, m_skip, m_jmp, m_rtn, m_fo, m_ff, m_wdis, m_addr, m_data};
  endfunction

  task automatic model_step(bit rst_n, bit v, logic [3:0] op, logic [2:0] a, bit d);
    bit di;
    {m_jmp, m_rtn, m_fo, m_ff} = 4'b0;
    m_wdis = 1'b1;
    if (!rst_n) begin
      {m_rr, m_ien, m_oen, m_skip, m_data} = 5'b0;
      m_addr = 3'd0;
      return;
    end
    if (!v) return;
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    di = d & m_ien;
    if (op >= 4'd1 && op <= 4'd7) m_rr = lu_tt[op][{m_rr, di}];
    else if (op == 4'd0) m_fo = 1'b1;
    else if (op == 4'd8 || op == 4'd9) begin
      if (m_oen) begin
        m_addr = a;
        m_data = m_rr ^ (op == 4'd9);
        m_wdis = 1'b0;
      end
    end
    else if (op == 4'd10) m_ien = d;
    else if (op == 4'd11) m_oen = d;
    else if (op == 4'd12) m_jmp = 1'b1;
    else if (op == 4'd13) begin
      m_rtn  = 1'b1;
      m_skip = 1'b1;
    end
    else if (op == 4'd14) m_skip = (m_rr == 1'b0);
    else m_ff = 1'b1;
  endtask

  // Apply one cycle of stimulus, advance the model, sample 1 ns after the edge.
  task automatic drive(bit rst_n, bit v, logic [3:0] op, logic [2:0] a, bit d);
    @(negedge clk);
    reset           = rst_n;
    bus.instr_valid = v;
    bus.instr       = op;
    bus.io_addr     = a;
    bus.data_in     = d;
    @(posedge clk);
    model_step(rst_n, v, op, a, d);
    #1;
  endtask

  task automatic exec(logic [3:0] op, logic [2:0] a, bit d);
    drive(1'b1, 1'b1, op, a, d);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, OP_STO, 3'd5, 1'b1);
    drive(1'b0, 1'b1, OP_STO, 3'd5, 1'b1);
    checks++;
    if (obs() !== 13'b0000_0000_1000_0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", obs(), 13'b0000_0000_1000_0);
    end
    checks++;
    if (obs() !== expv()) begin
      errors++;
      $display("FAIL reset_model: got %b want %b", obs(), expv());
    end
  endtask

  task automatic test_store();
    exec(OP_IEN, 3'd0, 1'b1);
    exec(OP_OEN, 3'd0, 1'b1);
    exec(OP_LD, 3'd0, 1'b1);
    exec(OP_STO, 3'd5, 1'b0);
    checks++;
    if ({bus.lat_addr, bus.lat_data, bus.lat_w_disable} !== {3'd5, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL store_write: got addr=%0d data=%b wdis=%b want 5 1 0",
               bus.lat_addr, bus.lat_data, bus.lat_w_disable);
    end
    drive(1'b1, 1'b0, OP_STO, 3'd2, 1'b0);
    checks++;
    if ({bus.lat_addr, bus.lat_data, bus.lat_w_disable} !== {3'd5, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL store_pulse_end: got addr=%0d data=%b wdis=%b want 5 1 1",
               bus.lat_addr, bus.lat_data, bus.lat_w_disable);
    end
  endtask

  task automatic test_gating();
    exec(OP_IEN, 3'd0, 1'b0);
    exec(OP_LD, 3'd0, 1'b1);
    checks++;
    if (bus.rr !== 1'b0) begin
      errors++;
      $display("FAIL ien_gate: got rr=%b want 0", bus.rr);
    end
    exec(OP_OEN, 3'd0, 1'b0);
    exec(OP_STO, 3'd3, 1'b0);
    checks++;
    if ({bus.lat_w_disable, bus.lat_addr, bus.lat_data} !== {1'b1, 3'd5, 1'b1}) begin
      errors++;
      $display("FAIL oen_gate: got wdis=%b addr=%0d data=%b want 1 5 1",
               bus.lat_w_disable, bus.lat_addr, bus.lat_data);
    end
  endtask

  task automatic test_skz();
    exec(OP_IEN, 3'd0, 1'b1);
    exec(OP_LD, 3'd0, 1'b0);
    exec(OP_SKZ, 3'd0, 1'b0);
    checks++;
    if (bus.skip !== 1'b1) begin
      errors++;
      $display("FAIL skz_set: got skip=%b want 1", bus.skip);
    end
    exec(OP_LD, 3'd0, 1'b1);
    checks++;
    if ({bus.rr, bus.skip} !== 2'b00) begin
      errors++;
      $display("FAIL skz_discard: got rr=%b skip=%b want 0 0", bus.rr, bus.skip);
    end
    exec(OP_LD, 3'd0, 1'b1);
    exec(OP_SKZ, 3'd0, 1'b0);
    exec(OP_LD, 3'd0, 1'b1);
    checks++;
    if ({bus.rr, bus.skip} !== 2'b10) begin
      errors++;
      $display("FAIL skz_noskip: got rr=%b skip=%b want 1 0", bus.rr, bus.skip);
    end
    exec(OP_LD, 3'd0, 1'b0);
    exec(OP_SKZ, 3'd0, 1'b0);
    exec(OP_SKZ, 3'd0, 1'b0);
    checks++;
    if (bus.skip !== 1'b0) begin
      errors++;
      $display("FAIL skz_double: got skip=%b want 0", bus.skip);
    end
  endtask

  task automatic test_rtn_jmp();
    exec(OP_RTN, 3'd0, 1'b0);
    checks++;
    if ({bus.rtn, bus.skip, bus.jmp} !== 3'b110) begin
      errors++;
      $display("FAIL rtn_pulse: got rtn=%b skip=%b jmp=%b want 1 1 0", bus.rtn, bus.skip, bus.jmp);
    end
    exec(OP_JMP, 3'd0, 1'b0);
    checks++;
    if ({bus.rtn, bus.skip, bus.jmp} !== 3'b000) begin
      errors++;
      $display("FAIL jmp_skipped: got rtn=%b skip=%b jmp=%b want 0 0 0", bus.rtn, bus.skip, bus.jmp);
    end
    exec(OP_NOPO, 3'd0, 1'b0);
    checks++;
    if ({bus.flag_o, bus.flag_f} !== 2'b10) begin
      errors++;
      $display("FAIL nopo_flag: got flag_o=%b flag_f=%b want 1 0", bus.flag_o, bus.flag_f);
    end
    exec(OP_NOPF, 3'd0, 1'b0);
    checks++;
    if ({bus.flag_o, bus.flag_f} !== 2'b01) begin
      errors++;
      $display("FAIL nopf_flag: got flag_o=%b flag_f=%b want 0 1", bus.flag_o, bus.flag_f);
    end
  endtask

  // Consecutive STO/STOC over all latch addresses, with a reset dropped in mid-walk.
  task automatic test_back_to_back();
    exec(OP_IEN, 3'd0, 1'b1);
    exec(OP_OEN, 3'd0, 1'b1);
    exec(OP_LD, 3'd0, 1'b1);
    for (int a = 0; a < 8; a++) begin
      exec((a % 2 == 0) ? OP_STO : OP_STOC, 3'(a), 1'b0);
      checks++;
      if ({bus.lat_w_disable, bus.lat_addr, bus.lat_data} !== {1'b0, 3'(a), a % 2 == 0}) begin
        errors++;
        $display("FAIL walk_write[%0d]: got wdis=%b addr=%0d data=%b want 0 %0d %0d",
                 a, bus.lat_w_disable, bus.lat_addr, bus.lat_data, a, a % 2 == 0);
      end
    end
    exec(OP_STO, 3'd6, 1'b0);
    drive(1'b0, 1'b1, OP_STO, 3'd7, 1'b1);
    checks++;
    if ({bus.lat_w_disable, bus.rr, bus.ien, bus.oen} !== 4'b1000) begin
      errors++;
      $display("FAIL walk_reset: got wdis=%b rr=%b ien=%b oen=%b want 1 0 0 0",
               bus.lat_w_disable, bus.rr, bus.ien, bus.oen);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      bit       rst_n = ($urandom_range(0, 29) != 0);
      bit       v     = ($urandom_range(0, 4) != 0);
      // Bias toward enabling IEN/OEN so stores and gated loads actually happen.
      logic [3:0] op  = 4'($urandom_range(0, 15));
      bit       d     = (op == OP_IEN || op == OP_OEN) ? ($urandom_range(0, 3) != 0)
                                                       : 1'($urandom_range(0, 1));
      drive(rst_n, v, op, 3'($urandom_range(0, 7)), d);
      checks++;
      if (obs() !== expv()) begin
        errors++;
        if (bad < 10) $display("FAIL random[%0d]: got %b want %b", i, obs(), expv());
        bad++;
      end
    end
  endtask

  initial begin
    lu_tt     = '{default: 4'b0};
    lu_tt[1]  = 4'b1010;  // LD
    lu_tt[2]  = 4'b0101;  // LDC
    lu_tt[3]  = 4'b1000;  // AND
    lu_tt[4]  = 4'b0100;  // ANDC
    lu_tt[5]  = 4'b1110;  // OR
    lu_tt[6]  = 4'b1101;  // ORC
    lu_tt[7]  = 4'b1001;  // XNOR
    bus.instr_valid = 1'b0;
    bus.instr       = 4'h0;
    bus.io_addr     = 3'd0;
    bus.data_in     = 1'b0;
    test_reset();
    test_store();
    test_gating();
    test_skz();
    test_rtn_jmp();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
